// File: rtl/spi_config_master.sv
// spi_config_master: SPI mode-0 master sending instr, optional 16-bit addr, then N payload bytes.
// Optional readback of MISO payload bytes is compiled in with SPI_CONFIG_MASTER_READBACK_EN.
// Pin outputs are registered from the current state, so they trail the FSM by one SCLK cycle.
module spi_config_master #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 8
) (
    input  logic             SCLK,
    input  logic             RESET,
    input  logic             start_i,
    input  logic [7:0]       instr_i,
    input  logic [15:0]      addr_i,
    input  logic             has_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [7:0]       tx_data_i,
    output logic             tx_ack_o,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             spi_sclk_o,
    output logic             spi_mosi_o,
    output logic             spi_ss_o,
    input  logic             spi_miso_i
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;
    localparam int RW = LEN_W + 2;
    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d, sh_q, sh_d;
    logic [2:0]       bit_q, bit_d;
    logic [RW-1:0]    rem_q, rem_d, nxt;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      addr_q, addr_d;
    logic             tx_ack_q, tx_ack_d, ss_q, sclk_q, mosi_q, busy_q, done_q;
    logic             cnt_done, byte_end, on_wire;

    assign cnt_done = cnt_q == 8'd0;
    assign byte_end = state_q == SHIFT_HI && cnt_done && bit_q == 3'd0;
    assign nxt      = rem_q - RW'(1);
    assign on_wire  = state_q inside {SETUP, SHIFT_LO, SHIFT_HI};

    // Next state, half-period timer, bit/byte counters and the byte loader
    always_comb begin
        state_d  = state_q;
        cnt_d    = (state_q == IDLE || cnt_done) ? DIV_M1 : cnt_q - 8'd1;
        sh_d     = sh_q;
        bit_d    = bit_q;
        rem_d    = rem_q;
        len_d    = len_q;
        addr_d   = addr_q;
        tx_ack_d = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = SETUP;
                len_d   = len_i;
                addr_d  = addr_i;
                sh_d    = instr_i;
                bit_d   = 3'd7;
                rem_d   = RW'(1) + (has_addr_i ? RW'(2) : RW'(0)) + RW'(len_i);
            end
            SETUP:    state_d = cnt_done ? SHIFT_LO : SETUP;
            SHIFT_LO: state_d = cnt_done ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI: if (cnt_done) begin
                bit_d   = bit_q - 3'd1;
                sh_d    = {sh_q[6:0], 1'b0};
                state_d = SHIFT_LO;
                if (bit_q == 3'd0) begin
                    rem_d    = nxt;
                    state_d  = (nxt == '0) ? HOLD : SHIFT_LO;
                    tx_ack_d = nxt != '0 && nxt <= RW'(len_q);
                    sh_d     = nxt > RW'(len_q) ? (nxt == RW'(len_q) + RW'(2) ? addr_q[15:8] : addr_q[7:0]) : tx_data_i;
                end
            end
            HOLD:    state_d = cnt_done ? GAP : HOLD;
            GAP:     state_d = cnt_done ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            bit_q    <= '0;
            rem_q    <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            tx_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            rem_q    <= rem_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            tx_ack_q <= tx_ack_d;
        end
    end

    // Glitch-free registered pins; done fires on the first IDLE cycle after a frame
    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            ss_q   <= 1'b1;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ss_q   <= !(on_wire || state_q == HOLD);
            sclk_q <= state_q == SHIFT_HI;
            mosi_q <= on_wire && sh_q[7];
            busy_q <= state_q != IDLE;
            done_q <= busy_q && state_q == IDLE;
        end
    end

    assign tx_ack_o   = tx_ack_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_ss_o   = ss_q;

`ifdef SPI_CONFIG_MASTER_READBACK_EN
    logic [7:0] rx_sh_q, rx_sh_d, rx_data_q;
    logic       rx_valid_q, pay_byte;

    assign pay_byte = rem_q <= RW'(len_q);

    // MISO is taken on the first cycle of SHIFT_HI, i.e. at the visible rising edge
    always_comb begin
        rx_sh_d = (state_q == SHIFT_HI && cnt_q == DIV_M1) ? {rx_sh_q[6:0], spi_miso_i} : rx_sh_q;
    end

    // Publish completed payload-position bytes only
    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= byte_end && pay_byte;
            if (byte_end && pay_byte) rx_data_q <= rx_sh_d;
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
`else
    logic unused_miso;
    assign unused_miso = spi_miso_i ^ byte_end;
    assign rx_data_o   = 8'h00;
    assign rx_valid_o  = 1'b0;
`endif
endmodule

// File: tb/tb_spi_config_master.sv
// tb_spi_config_master: scoreboard bench with an SPI slave model for two clock-divider builds.
module tb_spi_config_master;
    logic        SCLK = 0, RESET = 1, start0 = 0, start1 = 0, has_addr = 0, miso = 0, sel = 0;
    logic [7:0]  instr = 0, tx_data = 0, len = 0, rx_data0, rx_data1;
    logic [15:0] addr = 0;
    logic [1:0]  tx_ack_w, rx_valid_w, busy_w, done_w, sclk_w, mosi_w, ss_w;
    logic        ss, sclk, mosi, busy, done, tx_ack, rx_valid;
    logic [7:0]  rx_data;

    spi_config_master #(.CLK_DIV(2), .LEN_W(8)) dut0 (
        .SCLK(SCLK), .RESET(RESET), .start_i(start0), .instr_i(instr), .addr_i(addr),
        .has_addr_i(has_addr), .len_i(len), .tx_data_i(tx_data), .tx_ack_o(tx_ack_w[0]),
        .rx_data_o(rx_data0), .rx_valid_o(rx_valid_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
        .spi_sclk_o(sclk_w[0]), .spi_mosi_o(mosi_w[0]), .spi_ss_o(ss_w[0]), .spi_miso_i(miso)
    );

    spi_config_master #(.CLK_DIV(1), .LEN_W(8)) dut1 (
        .SCLK(SCLK), .RESET(RESET), .start_i(start1), .instr_i(instr), .addr_i(addr),
        .has_addr_i(has_addr), .len_i(len), .tx_data_i(tx_data), .tx_ack_o(tx_ack_w[1]),
        .rx_data_o(rx_data1), .rx_valid_o(rx_valid_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
        .spi_sclk_o(sclk_w[1]), .spi_mosi_o(mosi_w[1]), .spi_ss_o(ss_w[1]), .spi_miso_i(miso)
    );

    assign ss       = ss_w[sel];
    assign sclk     = sclk_w[sel];
    assign mosi     = mosi_w[sel];
    assign busy     = busy_w[sel];
    assign done     = done_w[sel];
    assign tx_ack   = tx_ack_w[sel];
    assign rx_valid = rx_valid_w[sel];
    assign rx_data  = sel ? rx_data1 : rx_data0;

    always #5 SCLK = ~SCLK;

    int cyc = 0;
    always @(posedge SCLK) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    int rises = 0, acks = 0, dones = 0, rxvs = 0, done_cyc = 0, rise1 = 0, rise2 = 0;
    int pidx = 0, nbit = 0, hi_run = 0, gap_last = 0;
    logic [7:0] cap = 0;
    logic prev_sclk = 0, prev_ss = 1;
    logic [7:0] exp_q[$], rx_q[$];
    logic [7:0] pay[8], resp[8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(negedge SCLK);
        if (done) begin dones++; done_cyc = cyc; end
        if (tx_ack) begin acks++; pidx++; tx_data = pay[pidx % 8]; end
        if (rx_valid) begin
            rxvs++;
            if (rx_q.size() > 0) chk("rx_data", rx_data, rx_q.pop_front());
            else chk("rx_queue", rx_q.size(), 1);
        end
        if (ss) begin
            nbit = 0;
            miso = 0;
            hi_run++;
        end else begin
            if (prev_ss) begin gap_last = hi_run; hi_run = 0; end
            if (sclk && !prev_sclk) begin
                rises++;
                if (rises == 1) rise1 = cyc;
                if (rises == 2) rise2 = cyc;
                cap = {cap[6:0], mosi};
                nbit++;
                if (nbit % 8 == 0) begin
                    if (exp_q.size() > 0) chk("mosi_byte", cap, exp_q.pop_front());
                    else chk("byte_queue", exp_q.size(), 1);
                end
            end
            if (!sclk) miso = resp[(nbit / 8) % 8][7 - nbit % 8];
        end
        prev_sclk = sclk;
        prev_ss = ss;
    end

    task automatic run_frame(input logic [7:0] ins, input logic [15:0] ad, input logic ha,
                             input int n, input int d, input int dup_at);
        int nb, k, c0, rx_exp;
        nb = 1 + (ha ? 2 : 0) + n;
        exp_q.push_back(ins);
        if (ha) begin exp_q.push_back(ad[15:8]); exp_q.push_back(ad[7:0]); end
        for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
`ifdef SPI_CONFIG_MASTER_READBACK_EN
        for (int i = 0; i < n; i++) rx_q.push_back(resp[nb - n + i]);
        rx_exp = n;
`else
        rx_exp = 0;
`endif
        @(negedge SCLK); #1;
        rises = 0; acks = 0; dones = 0; rxvs = 0; pidx = 0;
        instr = ins; addr = ad; has_addr = ha; len = 8'(n); tx_data = pay[0];
        start0 = !sel; start1 = sel;
        @(negedge SCLK); #1;
        start0 = 0; start1 = 0;
        c0 = cyc;
        k = 0;
        while (dones == 0 && k < 4000) begin
            @(negedge SCLK); #1;
            k++;
            if (k == dup_at) begin instr = 8'hEE; start0 = !sel; start1 = sel; end
            else begin start0 = 0; start1 = 0; end
        end
        chk("done_seen", dones, 1);
        chk("frame_len", done_cyc - c0, d * (3 + 16 * nb) + 1);
        chk("first_rise", rise1 - c0, 1 + 2 * d);
        chk("sclk_period", rise2 - rise1, 2 * d);
        chk("rises", rises, 8 * nb);
        chk("tx_acks", acks, n);
        chk("bytes_left", exp_q.size(), 0);
        chk("rx_valids", rxvs, rx_exp);
        chk("rx_left", rx_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int i = 0; i < 8; i++) begin pay[i] = 0; resp[i] = 0; end
        repeat (2) @(negedge SCLK);
        #1;
        chk("rst_ss", ss, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_ack", tx_ack, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        RESET = 0;

        @(negedge SCLK); #1;
        instr = 8'h01; has_addr = 0; len = 0; dones = 0;
        start0 = 1;
        @(negedge SCLK); #1;
        start0 = 0;
        c0 = cyc;
        repeat (20) @(negedge SCLK);
        #1;
        chk("mid_ss", ss, 0);
        chk("mid_busy", busy, 1);
        RESET = 1;
        #1;
        chk("mrst_ss", ss, 1);
        chk("mrst_sclk", sclk, 0);
        chk("mrst_mosi", mosi, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_edge", cyc - c0, 20);
        repeat (2) @(negedge SCLK);
        #1;
        RESET = 0;
        repeat (60) @(negedge SCLK);
        #1;
        chk("mrst_no_done", dones, 0);

        run_frame(8'hA5, 16'h0000, 0, 0, 2, -1);

        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_frame(8'h02, 16'h0012, 1, 3, 2, -1);

        pay[0] = 8'h00; pay[1] = 8'h00; pay[2] = 8'h00;
        resp[3] = 8'h5A; resp[4] = 8'hC3;
        run_frame(8'h03, 16'h0005, 1, 2, 2, -1);
        resp[3] = 8'h00; resp[4] = 8'h00;

        run_frame(8'h81, 16'h0000, 0, 0, 2, 30);
        repeat (60) @(negedge SCLK);
        #1;
        chk("dup_dones", dones, 1);
        chk("dup_bytes", exp_q.size(), 0);

        run_frame(8'h40, 16'h0000, 0, 0, 2, -1);
        run_frame(8'h41, 16'h0000, 0, 0, 2, -1);
        chk("gap_min", gap_last >= 3, 1);

        repeat (4) @(negedge SCLK);
        #1;
        sel = 1;
        repeat (2) @(negedge SCLK);
        pay[0] = 8'hFF;
        run_frame(8'h02, 16'h1234, 1, 1, 1, -1);

        repeat (4) @(negedge SCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_config_master.md
# spi_config_master

Byte-oriented SPI mode-0 master that generates the frames the on-chip SPI configuration slave expects. Each frame is an instruction byte, an optional 16-bit address (MSB then LSB), then N payload bytes. The block is used in the test harness and in companion controllers to load clock-divider, input-spike and debug configuration into the SNN memory. With the readback option compiled in, it also reads memory contents back over MISO.

## Interface
Parameters:
- CLK_DIV, 2, SCLK cycles per SPI half-period; legal 1..255.
- LEN_W, 8, width of the payload byte count.

Ports:
- SCLK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- instr  in  8  instruction byte, latched on accepted start.
- addr  in  16  address, latched on accepted start.
- has_addr  in  1  1 = send addr[15:8] then addr[7:0] after instr.
- len  in  LEN_W  payload byte count, latched on start; 0 allowed.
- tx_data  in  8  next payload byte.
- tx_ack  out  1  one-cycle pulse when tx_data is latched into the shifter.
- rx_data  out  8  last received payload byte.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- busy  out  1  high from the cycle after accepted start until the end of GAP.
- done  out  1  one-cycle pulse at the end of a frame.
- spi_sclk  out  1  serial clock; idles low.
- spi_mosi  out  1  serial data out, MSB first.
- spi_ss  out  1  slave select, active low.
- spi_miso  in  1  serial data in.

## Operation
- FSM states: IDLE -> SETUP -> SHIFT_LO <-> SHIFT_HI -> HOLD -> GAP -> IDLE.
- IDLE: spi_ss=1, spi_sclk=0, spi_mosi=0. On start: latch instr/addr/has_addr/len, compute nbytes = 1 + 2*has_addr + len, load the shifter with instr, go to SETUP.
- SETUP: spi_ss=0 and spi_mosi=bit7 for CLK_DIV cycles.
- SHIFT_LO (CLK_DIV cycles): spi_sclk=0, spi_mosi holds the current bit.
- SHIFT_HI (CLK_DIV cycles): spi_sclk=1. spi_miso is sampled into the rx shifter on entry, at the rising edge.
- On leaving SHIFT_HI after bit 0, the byte is complete:
  - decrement the byte counter;
  - if bytes remain, load the next byte: addr MSB, then addr LSB, then payload. Loading a payload byte pulses tx_ack in the same cycle.
  - if none remain, go to HOLD.
- HOLD: spi_ss=0, spi_sclk=0 for CLK_DIV cycles.
- GAP: spi_ss=1 for CLK_DIV cycles, then done pulses, busy drops and the FSM returns to IDLE.
- tx_data contract: the first payload byte is valid at start. Each following byte is valid no later than one cycle after the previous tx_ack.
- rx_valid pulses only for payload-position bytes, one cycle after the byte completes. Header bytes are never reported.
- start while busy is ignored (no queueing).
- RESET, including mid-frame: immediately spi_ss=1, spi_sclk=0, spi_mosi=0, all counters cleared, state IDLE, no done pulse.

## Timing
- Reset values: spi_ss=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, tx_ack=0, rx_valid=0, rx_data=8'h00.
- Start sampled at edge 0: spi_ss falls and busy rises at edge 1.
- First spi_sclk rise at edge 1+CLK_DIV+CLK_DIV.
- Frame length from start to the done pulse: CLK_DIV*(1 + 16*nbytes + 1 + 1) cycles, plus 1.
  - Example: CLK_DIV=2, nbytes=1 gives a done pulse at edge 39.
- spi_mosi changes only while spi_sclk is low, at least CLK_DIV cycles before the rising edge. This meets the slave, which samples on the rising edge.
- Minimum spi_ss high time between frames: CLK_DIV cycles (GAP) + 1.

## Configuration
- Macro SPI_CONFIG_MASTER_READBACK_EN.
- Defined: the rx shifter, rx_data and rx_valid behave as described above.
- Undefined: spi_miso is ignored, rx_data is tied 8'h00, rx_valid is tied 0, and no rx logic is synthesized. All transmit timing is identical in both builds.

## Test plan
- Reset mid-frame: start instr=8'h01 with CLK_DIV=2, assert RESET at edge 20 -> spi_ss=1, spi_sclk=0, busy=0 the same cycle; no done pulse; a new start afterwards works normally.
- Header only: instr=8'hA5, has_addr=0, len=0, CLK_DIV=2 -> 8 spi_sclk rises; slave model captures 8'hA5; done pulse at edge 39; no tx_ack.
- Write frame: instr=8'h02, addr=16'h0012, len=3, payload 8'h11/8'h22/8'h33 -> slave captures 02,00,12,11,22,33; exactly 3 tx_ack pulses; 48 spi_sclk rises in total.
- Readback (macro defined): instr=8'h03, addr=16'h0005, len=2, slave returns 8'h5A then 8'hC3 in the payload positions -> rx_valid pulses twice with rx_data 5A then C3; macro undefined -> rx_valid stays 0.
- Start ignored while busy: a second start pulse mid-frame -> the frame is unchanged and exactly one done pulse occurs. Back-to-back frames: spi_ss high for >= CLK_DIV+1 cycles between them.
- CLK_DIV=1 boundary: len=1, payload 8'hFF -> spi_sclk period 2 cycles, slave captures the full header and payload, and the frame length matches the timing formula.
